// File: rtl/backprop_sequencer_if.sv
// Bundle between the backprop sequencer, the training FSM, the weight/activation
// memories and the weight/delta datapath.
interface backprop_sequencer_if #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 10,
  parameter int HiddenNeuron = 16
);
  logic                    start;
  logic [4:0]              n_src;
  logic [AWIDTH-1:0]       w_base;
  logic [AWIDTH-1:0]       a_base;
  logic [DWIDTH-1:0]       act_data;

  logic                    busy;
  logic                    done;
  logic [AWIDTH-1:0]       w_addr;
  logic                    w_en;
  logic                    w_we;
  logic [AWIDTH-1:0]       act_addr;
  logic                    act_en;
  logic [DWIDTH-1:0]       save_a;
  logic                    enable_write_w;
  logic                    enable_delta;
  logic [HiddenNeuron-1:0] enable_calc_delta;
  logic [4:0]              neuron_idx;

  // Sequencer side
  modport slave (
    input  start, n_src, w_base, a_base, act_data,
    output busy, done, w_addr, w_en, w_we, act_addr, act_en, save_a,
           enable_write_w, enable_delta, enable_calc_delta, neuron_idx
  );

  // Controller / memory / datapath side
  modport master (
    output start, n_src, w_base, a_base, act_data,
    input  busy, done, w_addr, w_en, w_we, act_addr, act_en, save_a,
           enable_write_w, enable_delta, enable_calc_delta, neuron_idx
  );
endinterface

// File: rtl/backprop_sequencer.sv
// Backprop weight/delta sequencer: per source neuron, fetch weight row and
// activation, strobe the datapath loads, write the row back, steer delta.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; latches N', bases and clears i on start
// READ    | w_en/act_en issued at base+i
// WAIT    | memory data valid; activation captured into save_a
// CALC    | datapath new-weight and next_delta registers load
// WRITE   | updated row written back, delta steered into slot i, i++
// DONE    | one-cycle done pulse, then back to IDLE
module backprop_sequencer #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 10,
  parameter int HiddenNeuron = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  backprop_sequencer_if.slave   bp
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [4:0] N_MAX = 5'(HiddenNeuron);

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        n_q, n_d;
  logic [AWIDTH-1:0] w_base_q, w_base_d;
  logic [AWIDTH-1:0] a_base_q, a_base_d;
  logic [DWIDTH-1:0] save_a_q, save_a_d;
  logic [4:0]        n_clamp;
  logic              in_slot;

  assign n_clamp = (bp.n_src > N_MAX) ? N_MAX : bp.n_src;

  // State and run-context registers; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      save_a_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      save_a_q <= save_a_d;
    end
  end

  // Next-state and run-context update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    save_a_d = save_a_q;
    case (state_q)
      S_IDLE: begin
        if (bp.start) begin
          n_d      = n_clamp;
          w_base_d = bp.w_base;
          a_base_d = bp.a_base;
          idx_d    = '0;
          state_d  = (n_clamp == 5'd0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        save_a_d = bp.act_data;
        state_d  = S_CALC;
      end
      S_CALC:  state_d = S_WRITE;
      S_WRITE: begin
        idx_d   = idx_q + 5'd1;
        state_d = ((idx_q + 5'd1) == n_q) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; addresses are only driven while a neuron is in flight.
  always_comb begin
    in_slot              = (state_q == S_READ) || (state_q == S_WAIT) ||
                           (state_q == S_CALC) || (state_q == S_WRITE);
    bp.busy              = (state_q != S_IDLE);
    bp.done              = (state_q == S_DONE);
    bp.w_addr            = in_slot ? (w_base_q + AWIDTH'(idx_q)) : '0;
    bp.act_addr          = in_slot ? (a_base_q + AWIDTH'(idx_q)) : '0;
    bp.w_en              = (state_q == S_READ);
    bp.act_en            = (state_q == S_READ);
    bp.w_we              = (state_q == S_WRITE);
    bp.enable_write_w    = (state_q == S_CALC);
    bp.enable_delta      = (state_q == S_CALC);
    bp.enable_calc_delta = (state_q == S_WRITE) ?
                           (HiddenNeuron'(1) << idx_q) : '0;
    bp.save_a            = save_a_q;
    bp.neuron_idx        = idx_q;
  end

endmodule

// File: doc/backprop_sequencer.md
# backprop_sequencer

Sequencer for the backpropagation weight/delta datapath of one layer. For each source neuron it fetches one weight row (16 weights, one per hidden neuron) from weight BRAM and the neuron's activation from activation memory. It then strobes the datapath's weight-write and delta capture enables, writes the updated row back to the same address, and steers the resulting delta into its one-hot slot. It sits between the top-level training FSM (start/done) and the weight/delta datapath plus its BRAMs.

## Interface
- DWIDTH, 32, activation data width (signed fixed point)
- AWIDTH, 10, weight and activation memory address width
- HiddenNeuron, 16, maximum source neurons per run; width of the delta slot vector
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request, sampled only in IDLE
- n_src  in  5  source neuron count N, latched on start; values > HiddenNeuron clamp to HiddenNeuron
- w_base  in  AWIDTH  weight row base address, latched on start
- a_base  in  AWIDTH  activation base address, latched on start
- act_data  in  DWIDTH  activation memory read data, 1-cycle synchronous read latency
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse at end of run
- w_addr  out  AWIDTH  weight BRAM address (read and write)
- w_en  out  1  weight BRAM read enable
- w_we  out  1  weight BRAM write enable; write data comes from the datapath's write_weight registers
- act_addr  out  AWIDTH  activation memory address
- act_en  out  1  activation memory read enable
- save_a  out  DWIDTH  registered activation driven to the datapath
- enable_write_w  out  1  datapath new-weight register load
- enable_delta  out  1  datapath next_delta register load
- enable_calc_delta  out  HiddenNeuron  one-hot delta slot load
- neuron_idx  out  5  current source neuron index i

## Operation
- State machine states: IDLE, READ, WAIT, CALC, WRITE, DONE.
- IDLE, start=1: latch N' = min(n_src, HiddenNeuron), w_base and a_base; clear i to 0.
  - N'=0: go to DONE.
  - Otherwise: go to READ.
- IDLE, start=0: stay in IDLE.
- READ: w_addr=w_base+i, act_addr=a_base+i, w_en=1, act_en=1. Go to WAIT.
- WAIT: memory data valid. save_a <= act_data at end of cycle. Go to CALC.
- CALC: enable_write_w=1, enable_delta=1. Datapath inputs (save_a, held BRAM_out) are stable. Go to WRITE.
- WRITE: w_we=1, w_addr=w_base+i, enable_calc_delta = 1<<i. Then i <= i+1; go to DONE if i+1 == N', else go to READ.
- DONE: done=1. Go to IDLE.
- Address arithmetic is modulo 2^AWIDTH: base+i wraps, no error is flagged.
- w_addr holds the value w_base+i from READ through WRITE. It is 0 in IDLE and DONE.
- act_addr holds a_base+i from READ through WRITE.
- save_a holds its last value outside WAIT.
- Every strobe (w_en, w_we, act_en, enable_write_w, enable_delta, enable_calc_delta, done) is high for exactly one cycle per event and 0 in all other states.
- start while busy is ignored; no queuing.
- Reset (any state, any time) returns to IDLE immediately. All outputs go to 0: busy, done, w_addr, w_en, w_we, act_addr, act_en, save_a, enable_write_w, enable_delta, enable_calc_delta, neuron_idx. An interrupted WRITE is not completed. A partially updated weight table is acceptable and is the caller's concern.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- For neuron i, READ occurs at cycle 1+4i, WAIT at 2+4i, CALC at 3+4i, WRITE at 4+4i.
- done is high in cycle 4N'+1. busy is high in cycles 1..4N'+1.
- N'=0: done in cycle 1, no memory or datapath strobes.
- next_delta is captured at the end of CALC. enable_calc_delta[i] in WRITE moves it into slot i at the end of WRITE.
- The datapath write_weight registers are valid during WRITE, the same cycle w_we is asserted.
- Throughput: 4 cycles per source neuron; back-to-back runs need 1 IDLE cycle between done and the next accepted start.

## Test plan
- N=3, w_base=100, a_base=200, act_data = memory model value: w_en at cycles 1,5,9 with w_addr 100,101,102; w_we at 4,8,12 with the same addresses; enable_calc_delta = 0x0001, 0x0002, 0x0004 at 4,8,12; done at cycle 13; save_a equals model data for address 200+i from cycle 3+4i.
- n_src=0 -> done at cycle 1, busy high only in cycle 1, no w_en, w_we or enable strobes.
- n_src=20 -> clamped to 16; last WRITE at cycle 64 with enable_calc_delta=0x8000; done at cycle 65.
- w_base=1022, N=3 -> w_addr sequence 1022, 1023, 0.
- start re-asserted during busy (cycles 2..10 with N=3) -> no effect; done still exactly once at cycle 13.
- rst asserted asynchronously mid-CALC of neuron 1 -> all outputs 0 before the next clock edge, state IDLE, no w_we. A fresh start after rst deasserts runs from i=0 with nominal timing.
